// File: rtl/register_file_1w_wide_1r_narrow_pkg.sv
// Shared types and helpers for the asymmetric register file: clear-FSM
// state encoding and the lane-offset helper used by the row and read mux.
package rf_asym_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Bit offset of a lane inside a wide row; lane 0 sits in the LSBs.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/register_file_1w_wide_1r_narrow_if.sv
// Bus bundle for the wide-write / narrow-read register file. The master side
// issues reads, writes and clear requests; the slave side is the register file.
interface register_file_1w_wide_1r_narrow_if #(
    parameter int unsigned WADDR_WIDTH = 5,
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned N_LANES     = 2
);
    localparam int unsigned LANE_BITS   = $clog2(N_LANES);
    localparam int unsigned RADDR_WIDTH = WADDR_WIDTH + LANE_BITS;

    logic                           ReadEnable;
    logic [RADDR_WIDTH-1:0]         ReadAddr;
    logic [RDATA_WIDTH-1:0]         ReadData;
    logic                           WriteEnable;
    logic [WADDR_WIDTH-1:0]         WriteAddr;
    logic [N_LANES-1:0]             WriteLaneEn;
    logic [N_LANES*RDATA_WIDTH-1:0] WriteData;
    logic                           ClearReq;
    logic                           ClearBusy;

    modport master (
        output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteLaneEn,
               WriteData, ClearReq,
        input  ReadData, ClearBusy
    );

    modport slave (
        input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteLaneEn,
               WriteData, ClearReq,
        output ReadData, ClearBusy
    );

endinterface

// File: rtl/register_file_1w_wide_1r_narrow_row.sv
// One storage row of N_LANES x RDATA_WIDTH flops with independent lane
// write enables. Storage is deliberately not reset.
module register_file_row
    import rf_asym_pkg::*;
#(
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned N_LANES     = 2
) (
    input  logic                           clk_i,
    input  logic [N_LANES-1:0]             we_i,
    input  logic [N_LANES*RDATA_WIDTH-1:0] wdata_i,
    output logic [N_LANES*RDATA_WIDTH-1:0] rdata_o
);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [RDATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk_i) begin
            if (we_i[k]) begin
                data_q <= wdata_i[lane_lsb(k, RDATA_WIDTH) +: RDATA_WIDTH];
            end
        end

        assign rdata_o[lane_lsb(k, RDATA_WIDTH) +: RDATA_WIDTH] = data_q;
    end

endmodule

// File: rtl/register_file_1w_wide_1r_narrow.sv
// Wide-write / narrow-read flop register file with a sequential clear engine.
// Define RF_WR_BYPASS_EN for write-first same-cycle read behaviour.
module register_file_1w_wide_1r_narrow
    import rf_asym_pkg::*;
#(
    parameter int unsigned WADDR_WIDTH = 5,
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned N_LANES     = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    register_file_1w_wide_1r_narrow_if.slave   bus
);

    localparam int unsigned W_N_ROWS    = 2 ** WADDR_WIDTH;
    localparam int unsigned WDATA_WIDTH = N_LANES * RDATA_WIDTH;
    localparam int unsigned LANE_BITS   = $clog2(N_LANES);
    localparam int unsigned RADDR_WIDTH = WADDR_WIDTH + LANE_BITS;
    localparam int unsigned LSEL_W      = (LANE_BITS > 0) ? LANE_BITS : 1;

    rf_state_e              state_q;
    logic [WADDR_WIDTH-1:0] cnt_q;
    logic                   busy_q;
    logic [RDATA_WIDTH-1:0] rdata_q;
    logic [RDATA_WIDTH-1:0] rdata_d;

    logic                   clearing;
    logic                   ext_wr;
    logic [WDATA_WIDTH-1:0] wdata;
    logic [WDATA_WIDTH-1:0] row_q [W_N_ROWS];
    logic [WADDR_WIDTH-1:0] rd_row;
    logic [LSEL_W-1:0]      rd_lane;

    assign clearing = (state_q == RF_CLEAR);
    // A write arriving with an accepted ClearReq is dropped along with the clear.
    assign ext_wr   = bus.WriteEnable && (state_q == RF_IDLE) && !bus.ClearReq;
    assign wdata    = clearing ? '0 : bus.WriteData;

    for (genvar r = 0; r < W_N_ROWS; r++) begin : g_row
        logic [N_LANES-1:0] row_we;

        // Reset gates storage writes so a mid-clear reset leaves the next row intact.
        always_comb begin
            row_we = '0;
            if (rst_n) begin
                if (clearing) begin
                    if (cnt_q == WADDR_WIDTH'(r)) row_we = '1;
                end else if (ext_wr && (bus.WriteAddr == WADDR_WIDTH'(r))) begin
                    row_we = bus.WriteLaneEn;
                end
            end
        end

        register_file_row #(
            .RDATA_WIDTH (RDATA_WIDTH),
            .N_LANES     (N_LANES)
        ) u_row (
            .clk_i   (clk),
            .we_i    (row_we),
            .wdata_i (wdata),
            .rdata_o (row_q[r])
        );
    end

    if (LANE_BITS == 0) begin : g_nolane
        assign rd_row  = bus.ReadAddr;
        assign rd_lane = '0;
    end else begin : g_lane
        assign rd_row  = bus.ReadAddr[RADDR_WIDTH-1:LANE_BITS];
        assign rd_lane = bus.ReadAddr[LANE_BITS-1:0];
    end

`ifdef RF_WR_BYPASS_EN
    logic wr_hit;

    always_comb begin
        wr_hit = 1'b0;
        if (clearing) begin
            wr_hit = (cnt_q == rd_row);
        end else begin
            wr_hit = ext_wr && (bus.WriteAddr == rd_row) && bus.WriteLaneEn[rd_lane];
        end
    end

    always_comb begin
        rdata_d = row_q[rd_row][lane_lsb(32'(rd_lane), RDATA_WIDTH) +: RDATA_WIDTH];
        if (wr_hit) begin
            rdata_d = wdata[lane_lsb(32'(rd_lane), RDATA_WIDTH) +: RDATA_WIDTH];
        end
    end
`else
    always_comb begin
        rdata_d = row_q[rd_row][lane_lsb(32'(rd_lane), RDATA_WIDTH) +: RDATA_WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (bus.ReadEnable) rdata_q <= rdata_d;
            case (state_q)
                RF_IDLE: begin
                    if (bus.ClearReq) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (cnt_q == '1) begin
                        state_q <= RF_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + WADDR_WIDTH'(1);
                    end
                end
                default: state_q <= RF_IDLE;
            endcase
        end
    end

    assign bus.ReadData  = rdata_q;
    assign bus.ClearBusy = busy_q;

endmodule

// File: tb/tb_register_file_1w_wide_1r_narrow.sv
// Directed scoreboard bench for the asymmetric register file: a 2x32 lane
// instance and a 4x16 lane instance sharing one clock and reset.
module tb_register_file_1w_wide_1r_narrow;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_1w_wide_1r_narrow_if #(.WADDR_WIDTH(5), .RDATA_WIDTH(32), .N_LANES(2)) bus_a ();
    register_file_1w_wide_1r_narrow_if #(.WADDR_WIDTH(3), .RDATA_WIDTH(16), .N_LANES(4)) bus_b ();

    register_file_1w_wide_1r_narrow #(.WADDR_WIDTH(5), .RDATA_WIDTH(32), .N_LANES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    register_file_1w_wide_1r_narrow #(.WADDR_WIDTH(3), .RDATA_WIDTH(16), .N_LANES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_a_q [$];
    logic [15:0] exp_b_q [$];
    logic [31:0] model_a [32][2];
    logic [15:0] model_b [8][4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.ReadEnable = 1'b0; bus_a.ReadAddr = '0; bus_a.WriteEnable = 1'b0;
        bus_a.WriteAddr = '0; bus_a.WriteLaneEn = '0; bus_a.WriteData = '0; bus_a.ClearReq = 1'b0;
        bus_b.ReadEnable = 1'b0; bus_b.ReadAddr = '0; bus_b.WriteEnable = 1'b0;
        bus_b.WriteAddr = '0; bus_b.WriteLaneEn = '0; bus_b.WriteData = '0; bus_b.ClearReq = 1'b0;
    endtask

    task automatic write_a(input logic [4:0] row, input logic [1:0] en, input logic [63:0] data);
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = row; bus_a.WriteLaneEn = en; bus_a.WriteData = data;
        tick();
        bus_a.WriteEnable = 1'b0; bus_a.WriteLaneEn = '0;
        if (en[0]) model_a[row][0] = data[31:0];
        if (en[1]) model_a[row][1] = data[63:32];
    endtask

    task automatic read_a(input string tag, input logic [5:0] addr);
        bus_a.ReadEnable = 1'b1; bus_a.ReadAddr = addr;
        exp_a_q.push_back(model_a[addr[5:1]][addr[0]]);
        tick();
        bus_a.ReadEnable = 1'b0;
        check(tag, bus_a.ReadData, exp_a_q.pop_front());
    endtask

    task automatic write_b(input logic [2:0] row, input logic [3:0] en, input logic [63:0] data);
        bus_b.WriteEnable = 1'b1; bus_b.WriteAddr = row; bus_b.WriteLaneEn = en; bus_b.WriteData = data;
        tick();
        bus_b.WriteEnable = 1'b0; bus_b.WriteLaneEn = '0;
        for (int k = 0; k < 4; k++) if (en[k]) model_b[row][k] = data[k*16 +: 16];
    endtask

    task automatic read_b(input string tag, input logic [4:0] addr);
        bus_b.ReadEnable = 1'b1; bus_b.ReadAddr = addr;
        exp_b_q.push_back(model_b[addr[4:2]][addr[1:0]]);
        tick();
        bus_b.ReadEnable = 1'b0;
        check(tag, {16'h0, bus_b.ReadData}, {16'h0, exp_b_q.pop_front()});
    endtask

    task automatic preload_all_ones();
        for (int r = 0; r < 32; r++) write_a(5'(r), 2'b11, '1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        logic [31:0] same_cycle_exp;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_rdata_a", bus_a.ReadData, 32'h0);
        check("reset_busy_a", {31'h0, bus_a.ClearBusy}, 32'h0);
        check("reset_rdata_b", {16'h0, bus_b.ReadData}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Full-row write, then lane reads
        write_a(5'd3, 2'b11, 64'hDEADBEEF_01234567);
        read_a("row3_lane0", 6'd6);
        read_a("row3_lane1", 6'd7);
        bus_a.ReadAddr = 6'd6;
        tick();
        check("hold_no_enable", bus_a.ReadData, 32'hDEADBEEF);

        // Partial lane writes merge into one row
        write_a(5'd5, 2'b01, 64'hAAAAAAAA_11111111);
        write_a(5'd5, 2'b10, 64'h22222222_BBBBBBBB);
        read_a("row5_lane0", 6'd10);
        read_a("row5_lane1", 6'd11);
        write_a(5'd5, 2'b00, '1);
        read_a("noop_lane0", 6'd10);
        read_a("noop_lane1", 6'd11);

        // Same-cycle read and write to one row
        write_a(5'd2, 2'b11, 64'h0);
`ifdef RF_WR_BYPASS_EN
        same_cycle_exp = 32'hCAFE0000;
`else
        same_cycle_exp = 32'h0;
`endif
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 5'd2; bus_a.WriteLaneEn = 2'b01;
        bus_a.WriteData = {32'h0, 32'hCAFE0000};
        bus_a.ReadEnable = 1'b1; bus_a.ReadAddr = 6'd4;
        exp_a_q.push_back(same_cycle_exp);
        tick();
        idle_inputs();
        model_a[2][0] = 32'hCAFE0000;
        check("same_cycle_rw", bus_a.ReadData, exp_a_q.pop_front());
        read_a("after_same_cycle", 6'd4);

        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 5'd2; bus_a.WriteLaneEn = 2'b01;
        bus_a.WriteData = {32'h55555555, 32'h12345678};
        bus_a.ReadEnable = 1'b1; bus_a.ReadAddr = 6'd5;
        exp_a_q.push_back(32'h0);
        tick();
        idle_inputs();
        model_a[2][0] = 32'h12345678;
        check("same_row_other_lane", bus_a.ReadData, exp_a_q.pop_front());

        // Full clear: write on the accepting cycle and during the clear are dropped
        preload_all_ones();
        bus_a.ClearReq = 1'b1;
        bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 5'd31; bus_a.WriteLaneEn = 2'b11;
        bus_a.WriteData = 64'h0BADF00D_0BADF00D;
        tick();
        idle_inputs();
        busy_cycles = 0;
        while (bus_a.ClearBusy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles == 5) begin
                bus_a.WriteEnable = 1'b1; bus_a.WriteAddr = 5'd0; bus_a.WriteLaneEn = 2'b11;
                bus_a.WriteData = 64'h12345678_9ABCDEF0;
            end
            if (busy_cycles == 10) bus_a.ClearReq = 1'b1;
            tick();
            bus_a.WriteEnable = 1'b0; bus_a.WriteLaneEn = '0; bus_a.ClearReq = 1'b0;
        end
        check("clear_busy_cycles", 32'(busy_cycles), 32'd32);
        for (int r = 0; r < 32; r++) begin
            model_a[r][0] = '0;
            model_a[r][1] = '0;
        end
        for (int a = 0; a < 64; a++) read_a($sformatf("cleared_addr%0d", a), 6'(a));

        // Reset ten cycles into a clear
        preload_all_ones();
        bus_a.ClearReq = 1'b1;
        tick();
        bus_a.ClearReq = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        bus_a.ReadEnable = 1'b1; bus_a.ReadAddr = 6'd40;
        tick();
        check("midclear_reset_busy", {31'h0, bus_a.ClearBusy}, 32'h0);
        check("midclear_reset_rdata", bus_a.ReadData, 32'h0);
        rst_n = 1'b1;
        bus_a.ReadEnable = 1'b0;
        for (int r = 0; r < 10; r++) begin
            model_a[r][0] = '0;
            model_a[r][1] = '0;
        end
        for (int a = 0; a < 64; a++) read_a($sformatf("partial_addr%0d", a), 6'(a));
        check("busy_stays_low", {31'h0, bus_a.ClearBusy}, 32'h0);

        // Four 16-bit lanes
        write_b(3'd1, 4'b1111, 64'h4444_3333_2222_1111);
        for (int a = 4; a < 8; a++) read_b($sformatf("b_addr%0d", a), 5'(a));
        write_b(3'd1, 4'b0100, 64'h0000_9999_0000_0000);
        read_b("b_lane2_update", 5'd6);
        read_b("b_lane3_kept", 5'd7);
        read_b("b_lane0_kept", 5'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file_1w_wide_1r_narrow.md
Name: register_file_1w_wide_1r_narrow

Overview:
Asymmetric flip-flop register file: one wide write port (N_LANES x RDATA_WIDTH bits, per-lane write enables) and one narrow read port (RDATA_WIDTH bits) with registered lane selection.
Generalises the fixed 64b-write/32b-read cut to any power-of-two lane count.
Adds an in-block sequential clear engine.
Sits between DMA-style wide writers and 32-bit core/accelerator readers in the SCM memory hierarchy.

Parameters:
WADDR_WIDTH, 5, write (row) address width; W_N_ROWS = 2**WADDR_WIDTH rows.
RDATA_WIDTH, 32, read width and lane width in bits.
N_LANES, 2, lanes per row; power of two, >=1; WDATA_WIDTH = N_LANES*RDATA_WIDTH.
LANE_BITS, $clog2(N_LANES), derived; 0 when N_LANES==1.
RADDR_WIDTH, WADDR_WIDTH+LANE_BITS, derived read address width.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  reset, synchronous, active-low.
ReadEnable  in  1  read request.
ReadAddr  in  RADDR_WIDTH  [RADDR_WIDTH-1:LANE_BITS] = row, [LANE_BITS-1:0] = lane.
ReadData  out  RDATA_WIDTH  registered read data.
WriteEnable  in  1  write request.
WriteAddr  in  WADDR_WIDTH  row to write.
WriteLaneEn  in  N_LANES  per-lane write enable; bit k gates WriteData[k*RDATA_WIDTH +: RDATA_WIDTH].
WriteData  in  N_LANES*RDATA_WIDTH  wide write data; lane 0 is the LSBs.
ClearReq  in  1  start clear of all rows.
ClearBusy  out  1  high while clear sequence runs.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk.
  - At reset: ReadData=0, ClearBusy=0, FSM=IDLE, clear counter=0.
  - Storage array is not reset; its contents are undefined until written or cleared.
- Read:
  - ReadEnable=1 at edge t, with row r and lane l -> ReadData = mem[r][l] after edge t+1. Latency 1.
  - ReadEnable=0 -> ReadData holds its previous value.
- Write:
  - WriteEnable=1 at an edge -> every lane k with WriteLaneEn[k]=1 updates mem[WriteAddr][k].
  - Lanes with enable 0 are unchanged. WriteLaneEn all-zero is a no-op.
- Read and write to the same row in the same cycle: ReadData returns the pre-write contents, unless RF_WR_BYPASS_EN is defined.
- Clear FSM states: IDLE, CLEAR.
  - IDLE: ClearReq=1 -> CLEAR, counter=0, ClearBusy=1 from the next cycle.
  - CLEAR: one row per cycle, row=counter, all lanes written with 0. Counter increments.
  - CLEAR, counter==W_N_ROWS-1: that row is cleared, then -> IDLE, ClearBusy=0. Total W_N_ROWS busy cycles.
  - ClearReq while in CLEAR: ignored; no restart.
- Interaction with clear:
  - External writes while ClearBusy=1 are dropped, including the write on the cycle ClearReq is accepted.
  - Reads while ClearBusy=1 are serviced normally. Rows not yet cleared return old data.
- Reset mid-clear: FSM -> IDLE, ClearBusy=0. Partially cleared storage stays as is.
- N_LANES==1: no lane bits; ReadAddr==row; behaviour is otherwise identical.

Optional Feature:
RF_WR_BYPASS_EN
- Defined: a same-cycle read of row r and lane l, while an accepted write targets row r with WriteLaneEn[l]=1, returns the new WriteData lane after 1 cycle (write-first).
  - During CLEAR, a read of the row being cleared returns 0.
- Undefined: read-first; old contents are returned in both cases.

Decomposition:
- Package rf_asym_pkg: clear-FSM state enum (RF_IDLE, RF_CLEAR) and a lane-slice helper function.
- One sub-module: register_file_row, holding one N_LANES x RDATA_WIDTH row with per-lane write enables.
  - The top generates W_N_ROWS instances plus the read mux, FSM and output register.

Test Plan:
- Reset, then write row 3 with lanes en=2'b11 and data 64'hDEADBEEF_01234567; read addr 6 then addr 7 -> ReadData 32'h01234567, then 32'hDEADBEEF, each 1 cycle after its ReadEnable.
- Write row 5 with en=2'b01 and data 64'hAAAAAAAA_11111111, then en=2'b10 and data 64'h22222222_BBBBBBBB; read addr 10 and 11 -> 32'h11111111 and 32'h22222222.
- Same-cycle write row 2 lane 0 =32'hCAFE0000 (old 32'h0) while reading addr 4 -> 32'h0 without the macro, 32'hCAFE0000 with RF_WR_BYPASS_EN.
- Pulse ClearReq with all rows preloaded with 32'hFFFFFFFF lanes -> ClearBusy high for exactly 32 cycles; a write issued during the clear is dropped; afterwards every read returns 0.
- Assert rst_n=0 for 1 cycle 10 cycles into a clear -> ClearBusy=0 and ReadData=0 next cycle; rows 0-9 read 0 and rows 10-31 keep their old data.
- N_LANES=4, RDATA_WIDTH=16: write row 1 with 64'h4444_3333_2222_1111; read addr 4..7 -> 16'h1111, 16'h2222, 16'h3333, 16'h4444.
